pipeline_monitor: RTL
=====================

// Module: pipeline_monitor
// PURPOSE
//  Parametrised on-chip debug monitor for the GAT accelerator pipeline (SPMM, DMVM, softmax, aggregation, ...).
//  Per channel: sticky vld/rdy flags and a saturating count of vld rising edges.
//  Arm-and-trigger capture buffer: snapshots a probe data bus once a probe address matches a runtime trigger.
//  All state is read through a single registered 32-bit window selected by rd_sel_i (ILA/VIO friendly).
// PARAMETERS
//  NUM_CH   4     handshake channels monitored (1..16; 2*NUM_CH <= 32)
//  CNT_W    16    event counter width (1..32), saturating
//  ADDR_W   14    probe/trigger address width
//  DATA_W   12    probe data width (1..32)
//  DEPTH    8     capture buffer entries (>=1)
//  MON_ID   32'h6A7E_0001  constant returned at rd_sel_i==0
//  SEL_W    6     read-select width; must cover 3+NUM_CH+DEPTH
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        async active-low reset
//  clr_i        in   1        sync clear of flags, counters, buffer, FSM
//  vld_i        in   NUM_CH   per-channel valid pulses
//  rdy_i        in   NUM_CH   per-channel ready pulses
//  arm_i        in   1        arm capture (honoured only in IDLE)
//  trig_addr_i  in   ADDR_W   trigger address
//  probe_vld_i  in   1        probe bus qualifier
//  probe_addr_i in   ADDR_W   probe address
//  probe_data_i in   DATA_W   probe data
//  rd_sel_i     in   SEL_W    readout select
//  debug_o      out  32       registered readout word
//  cap_state_o  out  2        FSM state (IDLE=0, ARMED=1, CAPT=2, DONE=3)
//  cap_done_o   out  1        high while state==DONE
// BEHAVIOUR
//  Reset (rst_n=0, async)
//   - All flags, counters, buffer entries, vld history and debug_o -> 0.
//   - FSM -> IDLE; cap_state_o=0, cap_done_o=0.
//  clr_i
//   - Same effect as reset but synchronous.
//   - Highest priority: any vld/rdy/arm/probe event in the clr_i cycle is dropped.
//  Sticky flags
//   - vld_flag[c] sets on any cycle with vld_i[c]=1; rdy_flag[c] likewise; cleared only by reset/clr_i.
//   - Flags are visible at readout the cycle after the event.
//  Event counters
//   - cnt[c] += 1 on a rising edge of vld_i[c] (vld_i[c] & ~vld_q[c], vld_q reset to 0).
//   - Level held N cycles counts once; saturates at 2^CNT_W-1, never wraps.
//  Capture FSM
//   - IDLE: arm_i -> ARMED. Trigger is not evaluated in the arm cycle.
//   - ARMED: probe_vld_i && probe_addr_i==trig_addr_i -> write probe_data_i to buf[0], wptr=1, go CAPT.
//     If DEPTH==1, go DONE instead.
//   - CAPT: every probe_vld_i cycle (address ignored) writes buf[wptr], wptr++.
//     Write of entry DEPTH-1 -> DONE.
//   - DONE: buffer frozen; further probe_vld_i ignored.
//   - arm_i outside IDLE is ignored. Leaving DONE requires clr_i (or reset).
//   - cap_cnt = wptr (0..DEPTH).
//  Readout (1-cycle latency: debug_o at edge N+1 reflects rd_sel_i and state sampled at edge N)
//   - sel 0: MON_ID
//   - sel 1: {zero, rdy_flag[NUM_CH-1:0], vld_flag[NUM_CH-1:0]}
//   - sel 2: {cap_state[31:30], zero, cap_cnt[15:0]}
//   - sel 3+c (c<NUM_CH): cnt[c], zero-extended
//   - sel 3+NUM_CH+k (k<DEPTH): buf[k], zero-extended; unwritten entries read 0
//   - any other sel: 32'hDEAD_BEEF
//  State read in the same cycle as an update returns the pre-update value.
// TESTING
//  1 Reset mid-run: counters non-zero, FSM in CAPT, pull rst_n low asynchronously.
//    -> debug_o=0 immediately; after release, sel0=MON_ID, sel1=0, cap_state_o=0.
//  2 vld_i[1] high 5 cycles, low 2, high 1 pulse (NUM_CH=4).
//    -> sel4 reads 2; sel1 reads 32'h0000_0002; rdy_i[3] pulse then sel1 reads 32'h0000_0082.
//  3 Saturation with CNT_W=4: 20 vld_i[0] edges.
//    -> sel3 reads 15, stays 15 after more edges.
//  4 Capture with DEPTH=8, trig_addr_i=10: arm; probes at addr 9 (data 7) then addr 10 (data 0x155), then 8 more probes data 1..8.
//    -> buf = {0x155,1..7}; cap_done_o=1; sel 3+NUM_CH+7 reads 7; data 8 not stored.
//  5 arm_i and a matching probe in the same cycle from IDLE.
//    -> no capture that cycle; state ARMED; the next matching probe captures.
//  6 clr_i coincident with vld_i[2] edge and trigger match in ARMED.
//    -> all counters 0, state IDLE, buffer 0; sel 99 (out of range) reads 32'hDEAD_BEEF.

Source files
------------

// File: rtl/pipeline_monitor_if.sv
// Debug monitor bus: handshake probes, capture probe bus, control and readout window.
// master drives stimulus and samples readout; slave is the monitor itself.
interface pipeline_monitor_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 12,
    parameter int unsigned SEL_W  = 6
);
    logic              clr_i;
    logic [NUM_CH-1:0] vld_i;
    logic [NUM_CH-1:0] rdy_i;
    logic              arm_i;
    logic [ADDR_W-1:0] trig_addr_i;
    logic              probe_vld_i;
    logic [ADDR_W-1:0] probe_addr_i;
    logic [DATA_W-1:0] probe_data_i;
    logic [SEL_W-1:0]  rd_sel_i;
    logic [31:0]       debug_o;
    logic [1:0]        cap_state_o;
    logic              cap_done_o;

    modport master (
        output clr_i, vld_i, rdy_i, arm_i, trig_addr_i,
        output probe_vld_i, probe_addr_i, probe_data_i, rd_sel_i,
        input  debug_o, cap_state_o, cap_done_o
    );

    modport slave (
        input  clr_i, vld_i, rdy_i, arm_i, trig_addr_i,
        input  probe_vld_i, probe_addr_i, probe_data_i, rd_sel_i,
        output debug_o, cap_state_o, cap_done_o
    );
endinterface

// File: rtl/pipeline_monitor.sv
// On-chip debug monitor: sticky handshake flags, saturating vld edge counters,
// arm-and-trigger capture buffer, all read through one registered 32-bit window.
module pipeline_monitor #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 12,
    parameter int unsigned DEPTH  = 8,
    parameter logic [31:0] MON_ID = 32'h6A7E_0001,
    parameter int unsigned SEL_W  = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    pipeline_monitor_if.slave  bus
);
    localparam int unsigned PTR_W    = $clog2(DEPTH + 1);
    localparam int unsigned BUF_BASE = 3 + NUM_CH;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_CAPT  = 2'd2,
        ST_DONE  = 2'd3
    } cap_state_e;

    logic [NUM_CH-1:0] vld_flag_q, vld_flag_d;
    logic [NUM_CH-1:0] rdy_flag_q, rdy_flag_d;
    logic [NUM_CH-1:0] vld_hist_q, vld_hist_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [DATA_W-1:0] buf_q [DEPTH];
    logic [DATA_W-1:0] buf_d [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    cap_state_e        state_q, state_d;
    logic              done_q, done_d;
    logic [31:0]       debug_q, debug_d;

    // Handshake flags and rising-edge counters
    always_comb begin
        vld_flag_d = vld_flag_q | bus.vld_i;
        rdy_flag_d = rdy_flag_q | bus.rdy_i;
        vld_hist_d = bus.vld_i;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            cnt_d[c] = cnt_q[c];
            if (bus.vld_i[c] && !vld_hist_q[c] && (cnt_q[c] != CNT_MAX)) begin
                cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end
        end
        if (bus.clr_i) begin
            vld_flag_d = '0;
            rdy_flag_d = '0;
            vld_hist_d = '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                cnt_d[c] = '0;
            end
        end
    end

    // Capture FSM next state and buffer writes
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        buf_d   = buf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.arm_i) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (bus.probe_vld_i && (bus.probe_addr_i == bus.trig_addr_i)) begin
                    buf_d[0] = bus.probe_data_i;
                    wptr_d   = PTR_W'(1);
                    state_d  = (DEPTH == 1) ? ST_DONE : ST_CAPT;
                end
            end
            ST_CAPT: begin
                if (bus.probe_vld_i) begin
                    for (int unsigned k = 0; k < DEPTH; k++) begin
                        if (wptr_q == PTR_W'(k)) buf_d[k] = bus.probe_data_i;
                    end
                    wptr_d = wptr_q + PTR_W'(1);
                    if (wptr_q == PTR_W'(DEPTH - 1)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.clr_i) begin
            state_d = ST_IDLE;
            wptr_d  = '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                buf_d[k] = '0;
            end
        end
        done_d = (state_d == ST_DONE);
    end

    // Readout mux over pre-update state
    always_comb begin
        debug_d = 32'hDEAD_BEEF;
        if (bus.rd_sel_i == SEL_W'(0)) debug_d = MON_ID;
        if (bus.rd_sel_i == SEL_W'(1)) debug_d = 32'({rdy_flag_q, vld_flag_q});
        if (bus.rd_sel_i == SEL_W'(2)) debug_d = {state_q, 14'd0, 16'(wptr_q)};
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (bus.rd_sel_i == SEL_W'(3 + c)) debug_d = 32'(cnt_q[c]);
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (bus.rd_sel_i == SEL_W'(BUF_BASE + k)) debug_d = 32'(buf_q[k]);
        end
        if (bus.clr_i) debug_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_flag_q <= '0;
            rdy_flag_q <= '0;
            vld_hist_q <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) buf_q[k] <= '0;
            wptr_q     <= '0;
            state_q    <= ST_IDLE;
            done_q     <= 1'b0;
            debug_q    <= '0;
        end else begin
            vld_flag_q <= vld_flag_d;
            rdy_flag_q <= rdy_flag_d;
            vld_hist_q <= vld_hist_d;
            for (int unsigned c = 0; c < NUM_CH; c++) cnt_q[c] <= cnt_d[c];
            for (int unsigned k = 0; k < DEPTH; k++) buf_q[k] <= buf_d[k];
            wptr_q     <= wptr_d;
            state_q    <= state_d;
            done_q     <= done_d;
            debug_q    <= debug_d;
        end
    end

    assign bus.debug_o     = debug_q;
    assign bus.cap_state_o = state_q;
    assign bus.cap_done_o  = done_q;

endmodule
